// File: rtl/bp_pkg.sv
// Shared types and sizing for the fetch-side branch predictor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bp_pkg;

  // Table sizing. BTB_ENTRIES must be a power of 2.
  localparam int XLEN        = 32;
  localparam int BTB_ENTRIES = 64;
  localparam int IDX_W       = $clog2(BTB_ENTRIES);
  localparam int TAG_W       = XLEN - IDX_W - 2;

  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  // Branch type codes, shared with the branch condition unit in execute.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_NONE = 3'd7
  } br_type_e;

  // 2-bit saturating counter states; bit 1 set means predict taken.
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// BTB storage: one registered read port (fetch), one write port (execute) with a combinational view of the entry at the write index for read-modify-write.
// Latency: rd_entry valid 1 cycle after rd_en; a same-cycle write to the read index is not visible (read-before-write).
// Backpressure: none; reads and writes are accepted every cycle.
// Ports: clk, rst_n (sync, active low), rd_en/rd_idx -> rd_entry, wr_idx -> wr_cur, wr_en/wr_entry.
module bp_table
  import bp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic [IDX_W-1:0] wr_idx,
  output btb_entry_t       wr_cur,
  input  logic             wr_en,
  input  btb_entry_t       wr_entry
);

  // Valid and counter need reset; tag and target do not, so they live in
  // separate arrays that can map onto plain RAM.
  logic             valid_q  [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q [BTB_ENTRIES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      rd_entry <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= wr_entry.valid;
        ctr_q[wr_idx]   <= wr_entry.ctr;
      end
      // Non-blocking update above means this read sees the old entry.
      if (rd_en) begin
        rd_entry.valid  <= valid_q[rd_idx];
        rd_entry.tag    <= tag_q[rd_idx];
        rd_entry.target <= target_q[rd_idx];
        rd_entry.ctr    <= ctr_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    wr_cur.valid  = valid_q[wr_idx];
    wr_cur.tag    = tag_q[wr_idx];
    wr_cur.target = target_q[wr_idx];
    wr_cur.ctr    = ctr_q[wr_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts at fetch, trains on execute resolution, raises mispredict/redirect.
// Latency: prediction 1 cycle after f_valid; mispredict/redirect 1 cycle after resolution.
// Backpressure: none; one lookup and one resolution accepted per cycle.
// Ports: f_valid/f_pc -> p_valid/p_taken/p_target; ex_* resolution -> mispredict/redirect_pc; br_count/mp_count statistics.
module branch_predictor
  import bp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_valid,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  input  logic            ex_valid,
  input  logic [2:0]      ex_br_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  btb_entry_t       rd_entry;
  btb_entry_t       wr_cur;
  btb_entry_t       wr_entry;
  logic             wr_en;
  logic [TAG_W-1:0] look_tag_q;
  logic [XLEN-1:0]  look_pc4_q;

  br_type_e         ex_type;
  logic             upd;
  logic             eff_taken;
  logic             ex_hit;
  logic             mp_now;
  logic [TAG_W-1:0] ex_tag;

  bp_table u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (f_valid),
    .rd_idx   (f_pc[IDX_W+1:2]),
    .rd_entry (rd_entry),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_cur   (wr_cur),
    .wr_en    (wr_en),
    .wr_entry (wr_entry)
  );

  // ---------------- Lookup side ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid    <= 1'b0;
      look_tag_q <= '0;
      look_pc4_q <= '0;
    end else begin
      p_valid <= f_valid;
      if (f_valid) begin
        look_tag_q <= f_pc[XLEN-1:IDX_W+2];
        look_pc4_q <= f_pc + INST_BYTES;
      end
    end
  end

  always_comb begin
    p_taken  = p_valid && rd_entry.valid && (rd_entry.tag == look_tag_q)
               && (rd_entry.ctr >= CTR_WT);
    p_target = p_taken ? rd_entry.target : look_pc4_q;
  end

  // ---------------- Resolution side ----------------
  assign ex_type   = br_type_e'(ex_br_type);
  assign ex_tag    = ex_pc[XLEN-1:IDX_W+2];
  assign upd       = ex_valid && (ex_type != BR_NONE);
  // Unconditional jumps are always taken whatever the condition unit says.
  assign eff_taken = ex_taken || (ex_type == BR_JAL);
  assign ex_hit    = wr_cur.valid && (wr_cur.tag == ex_tag);
  assign mp_now    = (eff_taken != ex_pred_taken)
                     || (eff_taken && (ex_pred_target != ex_target));

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = wr_cur;
    if (upd) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (eff_taken) begin
          wr_entry.ctr    = ctr_inc(wr_cur.ctr);
          wr_entry.target = ex_target;
        end else begin
          wr_entry.ctr = ctr_dec(wr_cur.ctr);
        end
      end else if (eff_taken) begin
        // Allocate on a taken miss, evicting whatever aliases into this slot.
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = ex_tag;
        wr_entry.target = ex_target;
        wr_entry.ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      mispredict <= upd && mp_now;
      if (upd) begin
        redirect_pc <= eff_taken ? ex_target : ex_pc + INST_BYTES;
        br_count    <= br_count + 32'd1;
        if (mp_now) mp_count <= mp_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        p_valid, p_taken;
  logic [31:0] p_target;
  logic        ex_valid;
  logic [2:0]  ex_br_type;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_taken, ex_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, mp_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_pc(f_pc),
    .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
    .ex_valid(ex_valid), .ex_br_type(ex_br_type), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        fv;   logic [31:0] fpc;
    logic        ev;   logic [2:0]  typ;  logic [31:0] epc;
    logic        tk;   logic [31:0] tgt;
    logic        ptk;  logic [31:0] ptgt;
    logic        e_pv; logic e_ptk; logic [31:0] e_ptgt;
    logic        e_mp; logic [31:0] e_rpc;
    logic [31:0] e_br; logic [31:0] e_mpc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(
      input logic fv, input logic [31:0] fpc,
      input logic ev, input logic [2:0] typ, input logic [31:0] epc,
      input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
      input logic e_pv, input logic e_ptk, input logic [31:0] e_ptgt,
      input logic e_mp, input logic [31:0] e_rpc,
      input logic [31:0] e_br, input logic [31:0] e_mpc);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.ev = ev; v.typ = typ; v.epc = epc;
    v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.e_pv = e_pv; v.e_ptk = e_ptk; v.e_ptgt = e_ptgt;
    v.e_mp = e_mp; v.e_rpc = e_rpc; v.e_br = e_br; v.e_mpc = e_mpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    f_valid = v.fv;  f_pc = v.fpc;
    ex_valid = v.ev; ex_br_type = v.typ; ex_pc = v.epc;
    ex_taken = v.tk; ex_target = v.tgt;
    ex_pred_taken = v.ptk; ex_pred_target = v.ptgt;
  endtask

  // Drive one vector, let one edge capture it, then compare against the
  // expectation queued when it was driven.
  task automatic step(input vec_t v, input int n);
    vec_t e;
    apply(v);
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", n);
    end else begin
      e = sb.pop_front();
      chk($sformatf("p_valid[%0d]", n), {31'd0, p_valid}, {31'd0, e.e_pv});
      if (e.e_pv) begin
        chk($sformatf("p_taken[%0d]", n), {31'd0, p_taken}, {31'd0, e.e_ptk});
        chk($sformatf("p_target[%0d]", n), p_target, e.e_ptgt);
      end
      chk($sformatf("mispredict[%0d]", n), {31'd0, mispredict}, {31'd0, e.e_mp});
      if (e.e_mp) chk($sformatf("redirect_pc[%0d]", n), redirect_pc, e.e_rpc);
      chk($sformatf("br_count[%0d]", n), br_count, e.e_br);
      chk($sformatf("mp_count[%0d]", n), mp_count, e.e_mpc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    apply(mk(0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_p_valid",    {31'd0, p_valid},    32'd0);
    chk("rst_p_taken",    {31'd0, p_taken},    32'd0);
    chk("rst_p_target",   p_target,            32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_redirect",   redirect_pc,         32'd0);
    chk("rst_br_count",   br_count,            32'd0);
    chk("rst_mp_count",   mp_count,            32'd0);
    rst_n = 1'b1;

    //             fv fpc           ev typ epc      tk tgt     ptk ptgt     pv ptk ptgt     mp rpc     br mpc
    vecs.push_back(mk(1,'h100,       0,0,0,        0,0,       0,0,        1,0,'h104,       0,0,       0,0));  // cold miss
    vecs.push_back(mk(0,0,           1,0,'h100,    1,'h80,    0,0,        0,0,0,           1,'h80,    1,1));  // allocate, mispredict
    vecs.push_back(mk(1,'h100,       0,0,0,        0,0,       0,0,        1,1,'h80,        0,0,       1,1));  // now predicted taken
    vecs.push_back(mk(1,'h100,       1,0,'h100,    0,'h80,    1,'h80,     1,1,'h80,        1,'h104,   2,2));  // RBW: old ctr=2; 2->1
    vecs.push_back(mk(1,'h100,       1,0,'h100,    0,0,       0,0,        1,0,'h104,       0,0,       3,2));  // RBW: old ctr=1; 1->0
    vecs.push_back(mk(1,'h100,       0,0,0,        0,0,       0,0,        1,0,'h104,       0,0,       3,2));
    vecs.push_back(mk(0,0,           1,0,'h100,    1,'h80,    1,'h80,     0,0,0,           0,0,       4,2));  // 0->1
    vecs.push_back(mk(0,0,           1,0,'h100,    1,'h80,    1,'h80,     0,0,0,           0,0,       5,2));  // 1->2
    vecs.push_back(mk(0,0,           1,0,'h100,    1,'h80,    1,'h80,     0,0,0,           0,0,       6,2));  // 2->3
    vecs.push_back(mk(0,0,           1,0,'h100,    1,'h80,    1,'h80,     0,0,0,           0,0,       7,2));  // saturate at 3
    vecs.push_back(mk(0,0,           1,0,'h100,    0,'h80,    1,'h80,     0,0,0,           1,'h104,   8,3));  // 3->2
    vecs.push_back(mk(1,'h100,       0,0,0,        0,0,       0,0,        1,1,'h80,        0,0,       8,3));  // still taken
    vecs.push_back(mk(0,0,           1,6,'h200,    0,'h400,   1,'h3F0,    0,0,0,           1,'h400,   9,4));  // JAL, evicts 0x100
    vecs.push_back(mk(1,'h200,       0,0,0,        0,0,       0,0,        1,1,'h400,       0,0,       9,4));
    vecs.push_back(mk(1,'h100,       0,0,0,        0,0,       0,0,        1,0,'h104,       0,0,       9,4));  // alias miss
    vecs.push_back(mk(1,'h200,       1,7,'h100,    1,'h80,    0,0,        1,1,'h400,       0,0,       9,4));  // not a branch
    vecs.push_back(mk(1,'h100,       0,0,'h100,    1,'h80,    0,0,        1,0,'h104,       0,0,       9,4));  // ex_valid=0
    vecs.push_back(mk(1,'hFFFFFFFC,  1,1,'h300,    0,'h80,    0,0,        1,0,'h0,         0,0,      10,4));  // pc+4 wrap; nt miss no write
    vecs.push_back(mk(1,'h200,       1,2,'h104,    1,'h50,    1,'h60,     1,1,'h400,       1,'h50,   11,5));  // target mismatch
    vecs.push_back(mk(1,'h106,       0,0,0,        0,0,       0,0,        1,1,'h50,        0,0,      11,5));  // pc[1:0] ignored

    foreach (vecs[i]) step(vecs[i], i);

    // Reset while a mispredict is registered.
    apply(mk(0,0, 1,0,'h100, 1,'h80, 0,0, 0,0,0, 0,0, 0,0));
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_mispredict", {31'd0, mispredict}, 32'd1);
    chk("pre_rst_mp_count",   mp_count,            32'd6);
    rst_n = 1'b0;
    apply(mk(1,'h200, 1,0,'h100, 1,'h80, 0,0, 0,0,0, 0,0, 0,0));
    @(posedge clk);
    @(negedge clk);
    chk("rst2_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst2_p_valid",    {31'd0, p_valid},    32'd0);
    chk("rst2_br_count",   br_count,            32'd0);
    chk("rst2_mp_count",   mp_count,            32'd0);
    rst_n = 1'b1;
    step(mk(1,'h200, 0,0,0, 0,0,0,0, 1,0,'h204, 0,0, 0,0), 100);
    step(mk(1,'h104, 0,0,0, 0,0,0,0, 1,0,'h108, 0,0, 0,0), 101);
    step(mk(1,'h100, 0,0,0, 0,0,0,0, 1,0,'h104, 0,0, 0,0), 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
